// File: rtl/usp_multi_auth.sv
// USP authentication engine for NUM_EV vehicles: registration table, XOR decrypt,
// magic/PUF check and per-id nonce replay rejection, with a timed valid/ready result port.
module usp_multi_auth #(
   parameter int unsigned       ID_W    = 16,
   parameter int unsigned       NONCE_W = 16,
   parameter int unsigned       MSG_W   = 64,
   parameter int unsigned       NUM_EV  = 4,
   parameter int unsigned       SLOT_W  = $clog2(NUM_EV),
   parameter logic [MSG_W-1:0]  ENC_KEY = 64'hDEADBEEFCAFEBABE,
   parameter logic [MSG_W-1:0]  TAG_KEY = 64'hCAFEBABEDEADBEEF,
   parameter logic [7:0]        MAGIC   = 8'h5A,
   parameter int unsigned       TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reg_valid,
   input  logic [ID_W-1:0]    reg_id,
   output logic               reg_ready,
   output logic               reg_ack,
   output logic               reg_err,
   output logic [SLOT_W-1:0]  reg_slot,
   input  logic               req_valid,
   input  logic [ID_W-1:0]    req_id,
   input  logic [NONCE_W-1:0] req_nonce,
   input  logic [MSG_W-1:0]   req_msg,
   input  logic               req_puf,
   output logic               req_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_pass,
   output logic [1:0]         out_err,
   output logic [ID_W-1:0]    out_id,
   output logic [MSG_W-1:0]   out_tag,
   output logic               drop,
   output logic [SLOT_W:0]    num_reg
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StReg, StVerify, StResp} state_e;

   state_e             r_state;
   logic [ID_W-1:0]    r_ids  [NUM_EV];
   logic [NONCE_W-1:0] r_last [NUM_EV];
   logic [NUM_EV-1:0]  r_valid;
   logic [ID_W-1:0]    r_id;
   logic [NONCE_W-1:0] r_nonce;
   logic [MSG_W-1:0]   r_msg;
   logic               r_puf;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_hit;
   logic [SLOT_W-1:0]  w_hit_slot;
   logic               w_free;
   logic [SLOT_W-1:0]  w_free_slot;
   logic [SLOT_W:0]    w_count;
   logic [MSG_W-1:0]   w_dec;

   assign reg_ready = (r_state == StIdle);
   assign req_ready = (r_state == StIdle);
   assign w_dec     = r_msg ^ ENC_KEY;

   // Descending scan so the lowest matching / free slot wins.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_slot  = '0;
      w_free      = 1'b0;
      w_free_slot = '0;
      w_count     = '0;
      for (int i = NUM_EV - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_ids[i] == r_id)) begin
            w_hit      = 1'b1;
            w_hit_slot = SLOT_W'(i);
         end
         if (!r_valid[i]) begin
            w_free      = 1'b1;
            w_free_slot = SLOT_W'(i);
         end
         w_count = w_count + {{SLOT_W{1'b0}}, r_valid[i]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_valid   <= '0;
         for (int i = 0; i < NUM_EV; i++) begin
            r_ids[i]  <= '0;
            r_last[i] <= '0;
         end
         r_id      <= '0;
         r_nonce   <= '0;
         r_msg     <= '0;
         r_puf     <= 1'b0;
         r_cnt     <= '0;
         reg_ack   <= 1'b0;
         reg_err   <= 1'b0;
         reg_slot  <= '0;
         out_valid <= 1'b0;
         out_pass  <= 1'b0;
         out_err   <= 2'd0;
         out_id    <= '0;
         out_tag   <= '0;
         drop      <= 1'b0;
         num_reg   <= '0;
      end else begin
         reg_ack <= 1'b0;
         drop    <= 1'b0;
         num_reg <= w_count;
         unique case (r_state)
            StIdle: begin
               if (reg_valid) begin
                  r_id    <= reg_id;
                  r_state <= StReg;
               end else if (req_valid) begin
                  r_id    <= req_id;
                  r_nonce <= req_nonce;
                  r_msg   <= req_msg;
                  r_puf   <= req_puf;
                  r_state <= StVerify;
               end
            end
            StReg: begin
               reg_ack <= 1'b1;
               r_state <= StIdle;
               if (w_hit) begin
                  reg_err  <= 1'b0;
                  reg_slot <= w_hit_slot;
               end else if (w_free) begin
                  reg_err              <= 1'b0;
                  reg_slot             <= w_free_slot;
                  r_ids[w_free_slot]   <= r_id;
                  r_valid[w_free_slot] <= 1'b1;
                  r_last[w_free_slot]  <= '0;
               end else begin
                  reg_err  <= 1'b1;
                  reg_slot <= '0;
               end
            end
            StVerify: begin
               out_valid <= 1'b1;
               out_id    <= r_id;
               r_cnt     <= '0;
               r_state   <= StResp;
               out_pass  <= 1'b0;
               out_tag   <= '0;
               if (!w_hit) begin
                  out_err <= 2'd1;
               end else if (r_nonce <= r_last[w_hit_slot]) begin
                  out_err <= 2'd2;
               end else if ((w_dec[7:0] != MAGIC) || !r_puf) begin
                  out_err <= 2'd3;
               end else begin
                  out_err            <= 2'd0;
                  out_pass           <= 1'b1;
                  out_tag            <= w_dec ^ TAG_KEY;
                  r_last[w_hit_slot] <= r_nonce;
               end
            end
            StResp: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= StIdle;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  out_valid <= 1'b0;
                  drop      <= 1'b1;
                  r_state   <= StIdle;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_usp_multi_auth.sv
// Self-checking bench for usp_multi_auth: directed scenarios plus randomized requests
// checked against a table-level reference model.
module tb_usp_multi_auth;

   localparam logic [63:0] ENC = 64'hDEADBEEFCAFEBABE;
   localparam logic [63:0] TAGK = 64'hCAFEBABEDEADBEEF;
   localparam logic [63:0] MOK = 64'h0123456789ABCDE4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_valid = 1'b0;
   logic [15:0] reg_id = '0;
   logic        reg_ready, reg_ack, reg_err;
   logic [1:0]  reg_slot;
   logic        req_valid = 1'b0;
   logic [15:0] req_id = '0;
   logic [15:0] req_nonce = '0;
   logic [63:0] req_msg = '0;
   logic        req_puf = 1'b0;
   logic        req_ready, out_valid, out_pass, drop;
   logic        out_ready = 1'b0;
   logic [1:0]  out_err;
   logic [15:0] out_id;
   logic [63:0] out_tag;
   logic [2:0]  num_reg;

   int n_checks = 0;
   int n_fail = 0;

   logic [15:0] m_id   [4];
   logic        m_vld  [4];
   logic [15:0] m_last [4];

   usp_multi_auth dut (
      .clk       (clk),
      .reset     (reset),
      .reg_valid (reg_valid),
      .reg_id    (reg_id),
      .reg_ready (reg_ready),
      .reg_ack   (reg_ack),
      .reg_err   (reg_err),
      .reg_slot  (reg_slot),
      .req_valid (req_valid),
      .req_id    (req_id),
      .req_nonce (req_nonce),
      .req_msg   (req_msg),
      .req_puf   (req_puf),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pass  (out_pass),
      .out_err   (out_err),
      .out_id    (out_id),
      .out_tag   (out_tag),
      .drop      (drop),
      .num_reg   (num_reg)
   );

   always #5 clk = ~clk;

   function automatic int m_find(input logic [15:0] id);
      for (int i = 0; i < 4; i++) if (m_vld[i] && m_id[i] == id) return i;
      return -1;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < 4; i++) if (!m_vld[i]) return i;
      return -1;
   endfunction

   function automatic logic [2:0] m_count();
      int c = 0;
      for (int i = 0; i < 4; i++) if (m_vld[i]) c++;
      return 3'(c);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 4; i++) begin
         m_id[i] = '0; m_vld[i] = 1'b0; m_last[i] = '0;
      end
   endtask

   task automatic do_reg(input logic [15:0] id, input string nm);
      int s;
      logic exp_err;
      logic [1:0] exp_slot;
      s = m_find(id);
      if (s < 0) begin
         s = m_free();
         if (s < 0) begin
            exp_err = 1'b1; exp_slot = 2'd0;
         end else begin
            exp_err = 1'b0; exp_slot = s[1:0];
            m_id[s] = id; m_vld[s] = 1'b1; m_last[s] = '0;
         end
      end else begin
         exp_err = 1'b0; exp_slot = s[1:0];
      end
      @(negedge clk);
      reg_valid = 1'b1; reg_id = id;
      @(negedge clk);
      reg_valid = 1'b0;
      n_checks++;
      if ({reg_ack, reg_ready} !== 2'b00) begin
         n_fail++; $display("FAIL %s_busy: ack/ready=%b required 00", nm, {reg_ack, reg_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({reg_ack, reg_err, reg_slot} !== {1'b1, exp_err, exp_slot}) begin
         n_fail++;
         $display("FAIL %s_ack: ack/err/slot=%b/%b/%0d required 1/%b/%0d", nm, reg_ack, reg_err,
                  reg_slot, exp_err, exp_slot);
      end
      @(negedge clk);
      n_checks++;
      if ({reg_ack, num_reg} !== {1'b0, m_count()}) begin
         n_fail++;
         $display("FAIL %s_num: ack=%b num_reg=%0d required ack=0 num_reg=%0d", nm, reg_ack,
                  num_reg, m_count());
      end
   endtask

   // Expected result from the table model; a pass advances the stored nonce.
   task automatic model_req(input logic [15:0] id, input logic [15:0] nonce,
                            input logic [63:0] msg, input logic puf,
                            output logic exp_pass, output logic [1:0] exp_err,
                            output logic [63:0] exp_tag);
      int s;
      logic [63:0] dec;
      dec = msg ^ ENC;
      s = m_find(id);
      if (s < 0) exp_err = 2'd1;
      else if (nonce <= m_last[s]) exp_err = 2'd2;
      else if (dec[7:0] != 8'h5A || !puf) exp_err = 2'd3;
      else exp_err = 2'd0;
      exp_pass = (exp_err == 2'd0);
      exp_tag = exp_pass ? (dec ^ TAGK) : 64'h0;
      if (exp_pass) m_last[s] = nonce;
   endtask

   task automatic drive_req(input logic [15:0] id, input logic [15:0] nonce,
                            input logic [63:0] msg, input logic puf);
      req_valid = 1'b1; req_id = id; req_nonce = nonce; req_msg = msg; req_puf = puf;
   endtask

   task automatic do_req(input logic [15:0] id, input logic [15:0] nonce, input logic [63:0] msg,
                         input logic puf, input int dly, input string nm);
      logic ep;
      logic [1:0] ee;
      logic [63:0] et;
      model_req(id, nonce, msg, puf, ep, ee, et);
      @(negedge clk);
      drive_req(id, nonce, msg, puf);
      out_ready = (dly == 0);
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if ({out_valid, req_ready} !== 2'b00) begin
         n_fail++; $display("FAIL %s_verify: valid/ready=%b required 00", nm, {out_valid, req_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_pass, out_err, out_id, out_tag} !== {1'b1, ep, ee, id, et}) begin
         n_fail++;
         $display("FAIL %s_result: v/pass/err/id/tag=%b/%b/%0d/%h/%h required 1/%b/%0d/%h/%h",
                  nm, out_valid, out_pass, out_err, out_id, out_tag, ep, ee, id, et);
      end
      for (int k = 0; k < dly; k++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, out_err, out_tag} !== {1'b1, ee, et}) begin
            n_fail++;
            $display("FAIL %s_hold: v/err/tag=%b/%0d/%h required 1/%0d/%h", nm, out_valid, out_err,
                     out_tag, ee, et);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, drop, req_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL %s_done: valid/drop/ready=%b required 001", nm, {out_valid, drop, req_ready});
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m_clear();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({reg_ack, reg_err, reg_slot, out_valid, out_pass, out_err, out_id, out_tag, drop,
           num_reg} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: some output nonzero (num_reg=%0d out_valid=%b)",
                            num_reg, out_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({reg_ready, req_ready} !== 2'b11) begin
         n_fail++; $display("FAIL reset_ready: ready=%b required 11", {reg_ready, req_ready});
      end
   endtask

   task automatic test_register();
      do_reg(16'h00EF, "reg_first");
      do_reg(16'h00EF, "reg_dup");
   endtask

   task automatic test_auth();
      n_checks++;
      if ((MOK ^ 64'h0123456789ABCDE4 ^ 64'hDEADBEEFCAFEBAE4 ^ ENC ^ TAGK) !==
          64'hCAFEBABEDEADBEB5) begin
         n_fail++; $display("FAIL tag_ref: bench tag constant inconsistent");
      end
      do_req(16'h00EF, 16'hA3B7, 64'hDEADBEEFCAFEBAE4, 1'b1, 0, "auth_pass");
      do_req(16'h00EF, 16'hA3B7, 64'hDEADBEEFCAFEBAE4, 1'b1, 0, "auth_replay");
      do_req(16'h00EF, 16'hA3B8, 64'hDEADBEEFCAFEBAE4, 1'b1, 0, "auth_next");
      do_req(16'h00EF, 16'hA3B9, 64'hDEADBEEFCAFEBAE5, 1'b1, 0, "auth_magic");
      do_req(16'h00EF, 16'hA3BA, 64'hDEADBEEFCAFEBAE4, 1'b0, 0, "auth_puf");
   endtask

   task automatic test_unknown_and_full();
      do_req(16'h1234, 16'h0001, MOK, 1'b1, 0, "unknown_id");
      do_reg(16'h0101, "reg_s1");
      do_reg(16'h0202, "reg_s2");
      do_reg(16'h0303, "reg_s3");
      do_reg(16'h0404, "reg_full");
   endtask

   task automatic test_random();
      logic [15:0] pool [5];
      logic [15:0] id, nonce;
      logic [63:0] msg;
      int s;
      pool[0] = 16'h00EF; pool[1] = 16'h0101; pool[2] = 16'h0202;
      pool[3] = 16'h0303; pool[4] = 16'h1234;
      for (int n = 0; n < 24; n++) begin
         id = pool[$urandom_range(0, 4)];
         s = m_find(id);
         if (s >= 0 && $urandom_range(0, 2) != 0) nonce = m_last[s] + 16'($urandom_range(0, 3));
         else nonce = 16'($urandom);
         msg = {$urandom, $urandom};
         msg[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hE4;
         do_req(id, nonce, msg, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 8)), "random");
      end
   endtask

   task automatic test_timeout();
      logic ep;
      logic [1:0] ee;
      logic [63:0] et;
      logic [15:0] nonce;
      int hi = 0;
      nonce = m_last[1] + 16'd1;
      model_req(16'h0101, nonce, MOK, 1'b1, ep, ee, et);
      out_ready = 1'b0;
      @(negedge clk);
      drive_req(16'h0101, nonce, MOK, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 40 && out_valid === 1'b1; k++) begin
         if (drop !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early_drop: drop=%b required 0 at cycle %0d", drop, k);
         end
         hi++;
         @(negedge clk);
      end
      n_checks++;
      if (hi != 15) begin
         n_fail++; $display("FAIL timeout_len: out_valid high %0d cycles required 15", hi);
      end
      n_checks++;
      if ({drop, req_ready} !== 2'b11) begin
         n_fail++; $display("FAIL timeout_drop: drop/ready=%b required 11", {drop, req_ready});
      end
      @(negedge clk);
      n_checks++;
      if (drop !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse: drop=%b required 0", drop);
      end
      do_req(16'h0101, nonce, MOK, 1'b1, 0, "timeout_nonce_kept");
   endtask

   task automatic test_nonce_max();
      do_req(16'h0202, 16'hFFFF, MOK, 1'b1, 0, "nmax_first");
      do_req(16'h0202, 16'hFFFF, MOK, 1'b1, 0, "nmax_again");
      do_req(16'h0202, 16'h0001, MOK, 1'b1, 0, "nmax_wrap");
   endtask

   task automatic test_reset_in_resp();
      out_ready = 1'b0;
      @(negedge clk);
      drive_req(16'h0303, 16'h0010, MOK, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_resp_enter: out_valid=%b required 1", out_valid);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp_async: out_valid=%b required 0", out_valid);
      end
      m_clear();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({num_reg, out_valid, req_ready} !== {3'd0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL rst_resp_state: num_reg=%0d valid=%b ready=%b required 0/0/1",
                            num_reg, out_valid, req_ready);
      end
      do_req(16'h00EF, 16'h0020, MOK, 1'b1, 0, "rst_forgot_id");
   endtask

   task automatic test_back_to_back();
      logic ep;
      logic [1:0] ee;
      logic [63:0] et;
      m_id[0] = 16'h0777; m_vld[0] = 1'b1; m_last[0] = '0;
      model_req(16'h0777, 16'h0005, MOK, 1'b1, ep, ee, et);
      @(negedge clk);
      reg_valid = 1'b1; reg_id = 16'h0777;
      drive_req(16'h0777, 16'h0005, MOK, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      reg_valid = 1'b0;
      n_checks++;
      if ({reg_ack, req_ready} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_reg_first: ack/ready=%b required 00", {reg_ack, req_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({reg_ack, reg_err, reg_slot, out_valid} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
         n_fail++; $display("FAIL b2b_ack: ack/err/slot/valid=%b/%b/%0d/%b required 1/0/0/0",
                            reg_ack, reg_err, reg_slot, out_valid);
      end
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_verify: out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_pass, out_err, out_tag} !== {1'b1, ep, ee, et}) begin
         n_fail++; $display("FAIL b2b_result: v/pass/err/tag=%b/%b/%0d/%h required 1/%b/%0d/%h",
                            out_valid, out_pass, out_err, out_tag, ep, ee, et);
      end
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if ({out_valid, num_reg} !== {1'b0, 3'd1}) begin
         n_fail++; $display("FAIL b2b_done: valid=%b num_reg=%0d required 0/1", out_valid, num_reg);
      end
      do_req(16'h0777, 16'h0006, MOK, 1'b1, 0, "b2b_follow");
   endtask

   initial begin
      test_reset();
      test_register();
      test_auth();
      test_unknown_and_full();
      test_random();
      test_timeout();
      test_nonce_max();
      test_reset_in_resp();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
